// File: rtl/arm_multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// arm_multicycle_ctrl
//   Multi-cycle control sequencer for a LEGv8 datapath. Each instruction walks
//   FETCH -> DECODE -> EXEC -> (MEM) -> (WB). Every step takes one clock.
//   FETCH and MEM stretch until the matching memory reports ready.
//
// Optional feature macro: ARM_PERF_CNT_EN
//   When defined, adds the cycle_cnt and instr_cnt performance counters.
//
// Ports
//   clk, reset_n       rising-edge clock, asynchronous active-low reset
//   opcode[10:0]       IR[31:21]; decoded in DECODE
//   alu_zero           ALU zero flag, used by CBZ in EXEC
//   imem_ready         instruction memory done (IR data valid this cycle)
//   dmem_ready         data memory done (load data valid / store committed)
//   imem_req, dmem_req memory requests (never high together)
//   ir_write           load IR from imem
//   pc_write, pc_src   PC update strobe; pc_src 0 = PC+4, 1 = branch target
//   control_*          datapath controls (aluop, alusrc, memRead, memwrite,
//                      regwrite, mem2reg)
//   mdr_write          latch load data
//   illegal            sticky undefined-opcode flag (TRAP)
//   busy               high in every state except BOOT and TRAP
//   cycle_cnt, instr_cnt  (ARM_PERF_CNT_EN only) busy cycles / retired instrs
// -----------------------------------------------------------------------------
module arm_multicycle_ctrl (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [10:0] opcode,
  input  logic        alu_zero,
  input  logic        imem_ready,
  input  logic        dmem_ready,
  output logic        imem_req,
  output logic        dmem_req,
  output logic        ir_write,
  output logic        pc_write,
  output logic        pc_src,
  output logic [1:0]  control_aluop,
  output logic        control_alusrc,
  output logic        control_memRead,
  output logic        control_memwrite,
  output logic        control_regwrite,
  output logic        control_mem2reg,
  output logic        mdr_write,
  output logic        illegal,
  output logic        busy
`ifdef ARM_PERF_CNT_EN
  ,
  output logic [31:0] cycle_cnt,
  output logic [31:0] instr_cnt
`endif
);

  typedef enum logic [2:0] {
    S_BOOT, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP
  } state_t;

  typedef enum logic [2:0] {
    C_B, C_CBZ, C_LDUR, C_STUR, C_ADD, C_SUB, C_AND, C_ORR
  } class_t;

  state_t r_state;
  class_t r_class;
  class_t w_class;
  logic   w_legal;

  // Opcode classification. B and CBZ carry immediate bits in their low
  // opcode field, so they match on a prefix only.
  always_comb begin
    w_legal = 1'b1;
    w_class = C_ADD;
    if (opcode[10:5] == 6'b000101) begin
      w_class = C_B;
    end else if (opcode[10:3] == 8'b10110100) begin
      w_class = C_CBZ;
    end else begin
      case (opcode)
        11'b11111000010: w_class = C_LDUR;
        11'b11111000000: w_class = C_STUR;
        11'b10001011000: w_class = C_ADD;
        11'b11001011000: w_class = C_SUB;
        11'b10001010000: w_class = C_AND;
        11'b10101010000: w_class = C_ORR;
        default:         w_legal = 1'b0;
      endcase
    end
  end

  // Sequencer state and latched instruction class.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_BOOT;
      r_class <= C_ADD;
    end else begin
      case (r_state)
        S_BOOT:   r_state <= S_FETCH;
        S_FETCH:  if (imem_ready) r_state <= S_DECODE;
        S_DECODE: begin
          if (w_legal) begin
            r_class <= w_class;
            r_state <= S_EXEC;
          end else begin
            r_state <= S_TRAP;
          end
        end
        S_EXEC: begin
          case (r_class)
            C_B, C_CBZ:     r_state <= S_FETCH;
            C_LDUR, C_STUR: r_state <= S_MEM;
            default:        r_state <= S_WB;
          endcase
        end
        S_MEM: begin
          if (dmem_ready) r_state <= (r_class == C_LDUR) ? S_WB : S_FETCH;
        end
        S_WB:    r_state <= S_FETCH;
        S_TRAP:  r_state <= S_TRAP;
        default: r_state <= S_BOOT;
      endcase
    end
  end

  // Outputs decode from the registered state and class. The ready-cycle
  // strobes (ir_write, mdr_write, STUR pc_write) and the CBZ pc_src are
  // qualified by the live handshake/flag inputs so that a zero-wait memory
  // completes in the first cycle of its step. Because the state register
  // resets asynchronously, all requests drop the moment reset_n falls.
  always_comb begin
    imem_req         = 1'b0;
    dmem_req         = 1'b0;
    ir_write         = 1'b0;
    pc_write         = 1'b0;
    pc_src           = 1'b0;
    control_aluop    = 2'b00;
    control_alusrc   = 1'b0;
    control_memRead  = 1'b0;
    control_memwrite = 1'b0;
    control_regwrite = 1'b0;
    control_mem2reg  = 1'b0;
    mdr_write        = 1'b0;
    illegal          = 1'b0;
    busy             = 1'b0;
    case (r_state)
      S_FETCH: begin
        busy     = 1'b1;
        imem_req = 1'b1;
        ir_write = imem_ready;
      end
      S_DECODE: busy = 1'b1;
      S_EXEC: begin
        busy = 1'b1;
        case (r_class)
          C_B: begin
            control_aluop = 2'b01;
            pc_write      = 1'b1;
            pc_src        = 1'b1;
          end
          C_CBZ: begin
            control_aluop = 2'b01;
            pc_write      = 1'b1;
            pc_src        = alu_zero;
          end
          C_LDUR, C_STUR: begin
            control_aluop  = 2'b00;
            control_alusrc = 1'b1;
          end
          default: control_aluop = 2'b10;
        endcase
      end
      S_MEM: begin
        // Address operands stay selected for the whole wait.
        busy             = 1'b1;
        dmem_req         = 1'b1;
        control_alusrc   = 1'b1;
        control_memRead  = (r_class == C_LDUR);
        control_memwrite = (r_class == C_STUR);
        mdr_write        = dmem_ready && (r_class == C_LDUR);
        pc_write         = dmem_ready && (r_class == C_STUR);
      end
      S_WB: begin
        busy             = 1'b1;
        control_regwrite = 1'b1;
        control_mem2reg  = (r_class == C_LDUR);
        pc_write         = 1'b1;
      end
      S_TRAP:  illegal = 1'b1;
      default: ;
    endcase
  end

`ifdef ARM_PERF_CNT_EN
  logic [31:0] r_cycle_cnt;
  logic [31:0] r_instr_cnt;

  // busy and pc_write are both 0 in TRAP, so the counters freeze there.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cycle_cnt <= 32'd0;
      r_instr_cnt <= 32'd0;
    end else begin
      if (busy)     r_cycle_cnt <= r_cycle_cnt + 32'd1;
      if (pc_write) r_instr_cnt <= r_instr_cnt + 32'd1;
    end
  end

  assign cycle_cnt = r_cycle_cnt;
  assign instr_cnt = r_instr_cnt;
`endif

endmodule

// File: tb/tb_arm_multicycle_ctrl.sv
// Testbench for arm_multicycle_ctrl. Each instruction is expanded into its
// expected per-cycle timeline (fetch waits, decode, exec, memory waits,
// writeback) from the instruction-class rules. That timeline is applied
// cycle by cycle, and every output is compared.
module tb_arm_multicycle_ctrl;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [10:0] opcode = '0;
  logic        alu_zero = 1'b0;
  logic        imem_ready = 1'b0;
  logic        dmem_ready = 1'b0;
  logic        imem_req, dmem_req, ir_write, pc_write, pc_src;
  logic [1:0]  control_aluop;
  logic        control_alusrc, control_memRead, control_memwrite;
  logic        control_regwrite, control_mem2reg, mdr_write, illegal, busy;
`ifdef ARM_PERF_CNT_EN
  logic [31:0] cycle_cnt, instr_cnt;
  logic [31:0] m_cyc = 32'd0;
  logic [31:0] m_ins = 32'd0;
`endif

  arm_multicycle_ctrl dut (
    .clk(clk), .reset_n(reset_n), .opcode(opcode), .alu_zero(alu_zero),
    .imem_ready(imem_ready), .dmem_ready(dmem_ready),
    .imem_req(imem_req), .dmem_req(dmem_req), .ir_write(ir_write),
    .pc_write(pc_write), .pc_src(pc_src), .control_aluop(control_aluop),
    .control_alusrc(control_alusrc), .control_memRead(control_memRead),
    .control_memwrite(control_memwrite), .control_regwrite(control_regwrite),
    .control_mem2reg(control_mem2reg), .mdr_write(mdr_write),
    .illegal(illegal), .busy(busy)
`ifdef ARM_PERF_CNT_EN
    , .cycle_cnt(cycle_cnt), .instr_cnt(instr_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       imem_req, dmem_req, ir_write, pc_write, pc_src;
    logic [1:0] aluop;
    logic       alusrc, mem_read, mem_write, reg_write, mem2reg, mdr_write;
    logic       illegal, busy;
  } out_t;

  typedef struct {
    logic [10:0] opc;
    logic        imr, dmr, zero;
    out_t        exp;
  } cyc_t;

  typedef struct {
    logic [10:0] opc;
    int          iw, dw;
    logic        zero;
    int          lat;
  } dir_t;

  localparam int K_B = 0, K_CBZ = 1, K_LD = 2, K_ST = 3, K_R = 4, K_ILL = 5;

  cyc_t q[$];
  int   total = 0;
  int   bad = 0;

  function automatic logic rb();
    return 1'($urandom);
  endfunction

  function automatic logic [10:0] r11();
    return 11'($urandom);
  endfunction

  function automatic int kind_of(input logic [10:0] o);
    casez (o)
      11'b000101?????: return K_B;
      11'b10110100???: return K_CBZ;
      11'b11111000010: return K_LD;
      11'b11111000000: return K_ST;
      11'b10001011000, 11'b11001011000,
      11'b10001010000, 11'b10101010000: return K_R;
      default: return K_ILL;
    endcase
  endfunction

  function automatic out_t o_busy();
    out_t o = '0;
    o.busy = 1'b1;
    return o;
  endfunction

  function automatic out_t actual();
    out_t a;
    a.imem_req  = imem_req;          a.dmem_req  = dmem_req;
    a.ir_write  = ir_write;          a.pc_write  = pc_write;
    a.pc_src    = pc_src;            a.aluop     = control_aluop;
    a.alusrc    = control_alusrc;    a.mem_read  = control_memRead;
    a.mem_write = control_memwrite;  a.reg_write = control_regwrite;
    a.mem2reg   = control_mem2reg;   a.mdr_write = mdr_write;
    a.illegal   = illegal;           a.busy      = busy;
    return a;
  endfunction

  task automatic check_out(input string tag, input out_t e);
    out_t a = actual();
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s t=%0t outputs act=%h exp=%h", tag, $time, a, e);
    end
`ifdef ARM_PERF_CNT_EN
    total++;
    if (cycle_cnt !== m_cyc || instr_cnt !== m_ins) begin
      bad++;
      $display("FAIL %s_cnt t=%0t act=%0d/%0d exp=%0d/%0d", tag, $time,
               cycle_cnt, instr_cnt, m_cyc, m_ins);
    end
    if (e.busy)     m_cyc++;
    if (e.pc_write) m_ins++;
`endif
  endtask

  task automatic chk_int(input string tag, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s act=%0d exp=%0d", tag, act, exp);
    end
  endtask

  task automatic push(input logic [10:0] opc, input logic imr, input logic dmr,
                      input logic z, input out_t e);
    cyc_t c;
    c.opc = opc; c.imr = imr; c.dmr = dmr; c.zero = z; c.exp = e;
    q.push_back(c);
  endtask

  // Expected timeline of one instruction; ready inputs are randomised
  // whenever the matching request is expected low.
  task automatic build_instr(input logic [10:0] opc, input int iw, input int dw,
                             input logic z, input int trap_cycles);
    int   k = kind_of(opc);
    out_t e;
    for (int i = 0; i <= iw; i++) begin
      e = o_busy(); e.imem_req = 1'b1; e.ir_write = (i == iw);
      push(r11(), (i == iw), rb(), rb(), e);
    end
    push(opc, rb(), rb(), rb(), o_busy());
    if (k == K_ILL) begin
      for (int i = 0; i < trap_cycles; i++) begin
        e = '0; e.illegal = 1'b1;
        push(r11(), rb(), rb(), rb(), e);
      end
      return;
    end
    e = o_busy();
    case (k)
      K_B:   begin e.aluop = 2'b01; e.pc_write = 1'b1; e.pc_src = 1'b1; end
      K_CBZ: begin e.aluop = 2'b01; e.pc_write = 1'b1; e.pc_src = z; end
      K_LD, K_ST: begin e.aluop = 2'b00; e.alusrc = 1'b1; end
      default: e.aluop = 2'b10;
    endcase
    push(r11(), rb(), rb(), z, e);
    if (k == K_LD || k == K_ST) begin
      for (int j = 0; j <= dw; j++) begin
        e = o_busy(); e.dmem_req = 1'b1; e.alusrc = 1'b1;
        e.mem_read = (k == K_LD); e.mem_write = (k == K_ST);
        if (j == dw) begin
          if (k == K_LD) e.mdr_write = 1'b1;
          else           e.pc_write  = 1'b1;
        end
        push(r11(), rb(), (j == dw), rb(), e);
      end
    end
    if (k == K_LD || k == K_R) begin
      e = o_busy(); e.reg_write = 1'b1; e.mem2reg = (k == K_LD); e.pc_write = 1'b1;
      push(r11(), rb(), rb(), rb(), e);
    end
  endtask

  // Apply up to max_n queued cycles (-1 = all). lat is the DUT-observed
  // cycle index of the first pc_write pulse plus one.
  task automatic run_q(input string tag, input int max_n,
                       output int lat, output int npc, output int nir);
    int n = 0;
    lat = 0; npc = 0; nir = 0;
    while (q.size() > 0 && (max_n < 0 || n < max_n)) begin
      cyc_t c = q.pop_front();
      @(negedge clk);
      opcode = c.opc; imem_ready = c.imr; dmem_ready = c.dmr; alu_zero = c.zero;
      #1;
      check_out(tag, c.exp);
      if (pc_write === 1'b1) begin
        if (npc == 0) lat = n + 1;
        npc++;
      end
      if (ir_write === 1'b1) nir++;
      n++;
    end
  endtask

  // Hold reset for n cycles checking all-zero outputs, release, check BOOT.
  task automatic do_reset(input int n);
    @(negedge clk);
    reset_n = 1'b0;
`ifdef ARM_PERF_CNT_EN
    m_cyc = 32'd0; m_ins = 32'd0;
`endif
    for (int i = 0; i < n; i++) begin
      imem_ready = rb(); dmem_ready = rb();
      #1 check_out("reset", '0);
      @(negedge clk);
    end
    reset_n = 1'b1;
    #1 check_out("boot", '0);
  endtask

  dir_t dir_tab[9];

  initial begin
    int lat, npc, nir;
    dir_tab[0] = '{11'b10001011000, 0, 0, 1'b0, 4};  // ADD
    dir_tab[1] = '{11'b11111000010, 0, 3, 1'b0, 8};  // LDUR, dmem 3 waits
    dir_tab[2] = '{11'b10110100101, 0, 0, 1'b1, 3};  // CBZ taken
    dir_tab[3] = '{11'b10110100011, 0, 0, 1'b0, 3};  // CBZ not taken
    dir_tab[4] = '{11'b11111000000, 2, 0, 1'b0, 6};  // STUR, imem 2 waits
    dir_tab[5] = '{11'b00010111111, 1, 0, 1'b0, 4};  // B, imem 1 wait
    dir_tab[6] = '{11'b11001011000, 0, 0, 1'b0, 4};  // SUB
    dir_tab[7] = '{11'b10001010000, 1, 0, 1'b0, 5};  // AND, imem 1 wait
    dir_tab[8] = '{11'b10101010000, 0, 0, 1'b0, 4};  // ORR

    do_reset(3);

    // Directed table
    for (int i = 0; i < 9; i++) begin
      build_instr(dir_tab[i].opc, dir_tab[i].iw, dir_tab[i].dw, dir_tab[i].zero, 0);
      run_q($sformatf("dir%0d", i), -1, lat, npc, nir);
      chk_int($sformatf("dir%0d_latency", i), lat, dir_tab[i].lat);
      chk_int($sformatf("dir%0d_pc_pulses", i), npc, 1);
      chk_int($sformatf("dir%0d_ir_pulses", i), nir, 1);
      $display("dir%0d opcode=%b latency=%0d", i, dir_tab[i].opc, lat);
    end

    // Illegal opcode: TRAP held, no further fetch; reset restarts fetching.
    build_instr(11'b00000000000, 0, 0, 1'b0, 6);
    run_q("trap", -1, lat, npc, nir);
    chk_int("trap_pc_pulses", npc, 0);
    $display("trap sequence done");
    do_reset(2);
    build_instr(11'b10001011000, 0, 0, 1'b0, 0);
    run_q("after_trap", -1, lat, npc, nir);
    chk_int("after_trap_latency", lat, 4);

    // Reset asserted during the MEM wait of an LDUR.
    build_instr(11'b11111000010, 0, 5, 1'b0, 0);
    run_q("ldur_pre_reset", 5, lat, npc, nir);
    q.delete();
    #2 reset_n = 1'b0;
`ifdef ARM_PERF_CNT_EN
    m_cyc = 32'd0; m_ins = 32'd0;
`endif
    #1 check_out("async_reset_mem", '0);
    $display("reset during MEM wait applied");
    do_reset(2);
    build_instr(11'b11111000010, 1, 1, 1'b0, 0);
    run_q("after_mem_reset", -1, lat, npc, nir);
    chk_int("after_mem_reset_latency", lat, 7);

    // Randomised instruction stream
    for (int i = 0; i < 150; i++) begin
      logic [10:0] opc;
      int sel = $urandom_range(0, 9);
      int iw = $urandom_range(0, 3);
      int dw = $urandom_range(0, 3);
      logic z = rb();
      opc = r11();
      case (sel)
        0: opc = {6'b000101, opc[4:0]};
        1: opc = {8'b10110100, opc[2:0]};
        2: opc = 11'b11111000010;
        3: opc = 11'b11111000000;
        4: opc = 11'b10001011000;
        5: opc = 11'b11001011000;
        6: opc = 11'b10001010000;
        7: opc = 11'b10101010000;
        default: ;
      endcase
      build_instr(opc, iw, dw, z, 3);
      run_q($sformatf("rnd%0d", i), -1, lat, npc, nir);
      $display("rnd%0d opcode=%b iw=%0d dw=%0d z=%0d", i, opc, iw, dw, z);
      if (kind_of(opc) == K_ILL) begin
        do_reset(1);
      end else begin
        chk_int($sformatf("rnd%0d_pc_pulses", i), npc, 1);
        chk_int($sformatf("rnd%0d_ir_pulses", i), nir, 1);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout act=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
